// File: rtl/psg_audio_dac.sv
// PSG audio back-end: per-channel mute mix, box-average decimation, attenuation, 1-bit sigma-delta.
// Latency: CE of a window's last sample at cycle t -> PCM/PCM_VALID at t+3; DAC_OUT one cycle after PCM.
// Backpressure: none; one sample per CE, CE may be high every CLK, no stall.
module psg_audio_dac #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [7:0]  CHANNEL_A,
    input  logic [7:0]  CHANNEL_B,
    input  logic [7:0]  CHANNEL_C,
    input  logic [2:0]  MUTE,
    input  logic [1:0]  VOLUME,
    output logic [15:0] PCM,
    output logic        PCM_VALID,
    output logic        DAC_OUT
);

    // Accumulator holds up to 2^AVG_LOG2 samples of 765; the counter needs
    // at least one bit even when every sample closes its own window.
    localparam int AW = 10 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [9:0]    mix;
    logic [9:0]    s1;
    logic          s1_v;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic [9:0]    avg;
    logic          avg_v;
    logic [15:0]   sd_acc;
    logic [16:0]   sd_sum;

    // Muted channels contribute zero to the three-way sum.
    always_comb begin
        mix = (MUTE[0] ? 10'd0 : {2'b00, CHANNEL_A})
            + (MUTE[1] ? 10'd0 : {2'b00, CHANNEL_B})
            + (MUTE[2] ? 10'd0 : {2'b00, CHANNEL_C});
    end

    assign acc_sum = acc + AW'(s1);
    assign sd_sum  = {1'b0, sd_acc} + {1'b0, PCM};

    // Stage 1: capture the mix only on the PSG clock enable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1   <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= CE;
            if (CE) s1 <= mix;
        end
    end

    // Stage 2: box average over 2^AVG_LOG2 samples; the last sample is folded in directly.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc   <= '0;
            cnt   <= '0;
            avg   <= '0;
            avg_v <= 1'b0;
        end else begin
            avg_v <= 1'b0;
            if (s1_v) begin
                if (cnt == CNT_LAST) begin
                    avg   <= 10'(acc_sum >> AVG_LOG2);
                    acc   <= '0;
                    cnt   <= '0;
                    avg_v <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Stage 3: scale to 16 bits and apply master attenuation sampled with the average.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PCM       <= '0;
            PCM_VALID <= 1'b0;
        end else begin
            PCM_VALID <= avg_v;
            if (avg_v) PCM <= {avg, 6'b0} >> VOLUME;
        end
    end

    // First-order sigma-delta: the accumulator carry is the output bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sd_acc  <= '0;
            DAC_OUT <= 1'b0;
        end else begin
            sd_acc  <= sd_sum[15:0];
            DAC_OUT <= sd_sum[16];
        end
    end

endmodule

// File: tb/tb_psg_audio_dac.sv
module tb_psg_audio_dac;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CE = 1'b0;
    logic [7:0]  CHANNEL_A = '0;
    logic [7:0]  CHANNEL_B = '0;
    logic [7:0]  CHANNEL_C = '0;
    logic [2:0]  MUTE = '0;
    logic [1:0]  VOLUME = '0;
    logic [15:0] PCM;
    logic        PCM_VALID;
    logic        DAC_OUT;
    logic [15:0] pcm0;
    logic        pcm_valid0;
    logic        dac_out0;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int n_v0 = 0;
    int last_ce = 0;
    int ce_at[16];
    int pulses[$];
    int waited;
    int ones;

    psg_audio_dac #(.AVG_LOG2(3)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .CHANNEL_A(CHANNEL_A), .CHANNEL_B(CHANNEL_B), .CHANNEL_C(CHANNEL_C),
        .MUTE(MUTE), .VOLUME(VOLUME),
        .PCM(PCM), .PCM_VALID(PCM_VALID), .DAC_OUT(DAC_OUT)
    );

    psg_audio_dac #(.AVG_LOG2(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .CHANNEL_A(CHANNEL_A), .CHANNEL_B(CHANNEL_B), .CHANNEL_C(CHANNEL_C),
        .MUTE(MUTE), .VOLUME(VOLUME),
        .PCM(pcm0), .PCM_VALID(pcm_valid0), .DAC_OUT(dac_out0)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one CLK and observe 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (PCM_VALID) pulses.push_back(cyc);
        if (pcm_valid0) n_v0++;
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        CE = 1'b0;
        repeat (n) tick();
        RESET = 1'b0;
        pulses.delete();
        n_v0 = 0;
    endtask

    task automatic ce_sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        CHANNEL_A = a;
        CHANNEL_B = b;
        CHANNEL_C = c;
        CE = 1'b1;
        last_ce = cyc;
        tick();
        CE = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!PCM_VALID && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        repeat (8) ce_sample(a, b, c);
    endtask

    initial begin
        // 1: reset with CE toggling and channels at full scale
        CHANNEL_A = 8'hFF; CHANNEL_B = 8'hFF; CHANNEL_C = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            CE = i[0];
            tick();
            chk("rst_pcm", PCM, 16'h0000);
            chk("rst_vld", PCM_VALID, 1'b0);
            chk("rst_dac", DAC_OUT, 1'b0);
        end
        RESET = 1'b0;
        CE = 1'b0;
        tick();
        chk("rel_pcm", PCM, 16'h0000);
        chk("rel_vld", PCM_VALID, 1'b0);
        chk("rel_dac", DAC_OUT, 1'b0);

        // 2: full scale, CE every 4th CLK
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            ce_sample(8'hFF, 8'hFF, 8'hFF);
            ce_at[i] = last_ce;
            repeat (3) tick();
        end
        chk("fs_npulse", pulses.size(), 2);
        if (pulses.size() >= 2) begin
            chk("fs_lat", pulses[0] - ce_at[7], 3);
            chk("fs_period", pulses[1] - pulses[0], 32);
        end
        chk("fs_pcm", PCM, 16'hBF40);
        chk("avg0_npulse", n_v0, 16);
        chk("avg0_pcm", pcm0, 16'hBF40);

        // 3: mute and attenuation
        do_reset(1);
        MUTE = 3'b110;
        VOLUME = 2'd0;
        window(8'h80, 8'hFF, 8'hFF);
        wait_valid(10, waited);
        chk("mute_lat", waited, 2);
        chk("mute_pcm", PCM, 16'h2000);
        VOLUME = 2'd2;
        window(8'h80, 8'hFF, 8'hFF);
        wait_valid(10, waited);
        chk("vol2_pcm", PCM, 16'h0800);
        chk("avg0_vol2", pcm0, 16'h0800);
        VOLUME = 2'd0;
        repeat (4) tick();
        chk("vol_hold", PCM, 16'h0800);

        // 4: averaging, with channel changes between CEs that must be ignored
        do_reset(1);
        MUTE = 3'b110;
        for (int i = 0; i < 8; i++) begin
            ce_sample((i < 4) ? 8'h00 : 8'hFF, 8'h33, 8'h44);
            CHANNEL_A = 8'h55;
            tick();
        end
        wait_valid(10, waited);
        chk("avg_pcm", PCM, 16'h1FC0);
        chk("avg_npulse", pulses.size(), 1);

        // 5: sigma-delta at 0x8000, 0x2000 and 0
        do_reset(1);
        MUTE = 3'b000;
        window(8'hFF, 8'hFF, 8'h02);
        wait_valid(10, waited);
        chk("sd_half_pcm", PCM, 16'h8000);
        chk("sd_half_dac0", DAC_OUT, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("sd_half_alt", DAC_OUT, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        MUTE = 3'b110;
        window(8'h80, 8'h00, 8'h00);
        wait_valid(10, waited);
        chk("sd_8th_pcm", PCM, 16'h2000);
        for (int w = 0; w < 2; w++) begin
            ones = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                ones += int'(DAC_OUT);
            end
            chk("sd_8th_ones", ones, 1);
        end
        MUTE = 3'b111;
        window(8'hFF, 8'hFF, 8'hFF);
        wait_valid(10, waited);
        chk("sd_zero_pcm", PCM, 16'h0000);
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            ones += int'(DAC_OUT);
        end
        chk("sd_zero_ones", ones, 0);

        // 6: reset mid-window (with CE high), then back-to-back CE
        do_reset(1);
        MUTE = 3'b110;
        repeat (5) ce_sample(8'hFF, 8'h00, 8'h00);
        RESET = 1'b1;
        CE = 1'b1;
        tick();
        RESET = 1'b0;
        CE = 1'b0;
        pulses.delete();
        window(8'h10, 8'h00, 8'h00);
        wait_valid(10, waited);
        chk("mid_pcm", PCM, 16'h0400);
        chk("mid_npulse", pulses.size(), 1);
        if (pulses.size() >= 1) chk("mid_lat", pulses[0] - last_ce, 3);
        tick();
        chk("mid_vld_1cyc", PCM_VALID, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/psg_audio_dac.md
# psg_audio_dac

Audio back-end for the PSG. It samples the three 8-bit channel outputs (CHANNEL_A/B/C) on the PSG clock enable and mixes them with per-channel mute. It decimates the mix with a box-average filter, applies master attenuation, and produces a 16-bit PCM word plus a first-order sigma-delta 1-bit stream for the board's RC-filtered audio pin. It sits directly downstream of the PSG, in the same clock domain.

## Interface
Parameters:
- AVG_LOG2, default 3: log2 of the number of CE samples averaged per PCM word. Legal range 0..4.

Ports:
- CLK  in  1  global clock.
- RESET  in  1  synchronous reset, active high.
- CE  in  1  PSG clock enable, the same strobe that drives the PSG; one sample is taken per CE cycle.
- CHANNEL_A  in  8  PSG channel A level, unsigned.
- CHANNEL_B  in  8  PSG channel B level, unsigned.
- CHANNEL_C  in  8  PSG channel C level, unsigned.
- MUTE  in  3  bit0 mutes A, bit1 mutes B, bit2 mutes C; a muted channel contributes 0.
- VOLUME  in  2  master attenuation; PCM is right-shifted by VOLUME (0 = full scale).
- PCM  out  16  unsigned mixed, averaged, attenuated sample.
- PCM_VALID  out  1  one-CLK pulse when PCM updates.
- DAC_OUT  out  1  sigma-delta bitstream; ones density = PCM/65536.

## Operation
Stage 1, sample:
- In a cycle with CE=1, register s1 = (MUTE[0]?0:A) + (MUTE[1]?0:B) + (MUTE[2]?0:C) as a 10-bit value (max 765).
- Set s1_v=1 for the next cycle; s1_v=0 otherwise. MUTE is sampled only in CE cycles.

Stage 2, average:
- acc is (10+AVG_LOG2) bits; cnt is AVG_LOG2 bits.
- When s1_v=1:
  - if cnt == 2^AVG_LOG2-1, load avg = (acc+s1)>>AVG_LOG2 (10 bits), clear acc and cnt, and set avg_v=1 for one cycle;
  - otherwise acc += s1 and cnt += 1.
- With AVG_LOG2=0, every sample produces an output.
- No overflow is possible: max acc = 765·16 < 2^14.

Stage 3, scale:
- When avg_v=1, PCM <= {avg, 6'b0} >> VOLUME, and PCM_VALID=1 for exactly that one cycle.
- Full scale is 765·64 = 48960 (0xBF40).
- VOLUME is sampled in the avg_v cycle; a change takes effect on the next PCM update only.

Sigma-delta, every CLK with no enable:
- {carry, sd_acc[15:0]} = sd_acc + PCM, computed as a 17-bit sum.
- DAC_OUT <= carry.
- A PCM change takes effect in the accumulation on the cycle after PCM updates.

Reset:
- RESET=1 clears PCM, PCM_VALID, DAC_OUT, sd_acc, acc, cnt, s1, s1_v, avg and avg_v.
- Reset has priority over CE. Reset mid-window discards the partial window; the first post-reset PCM averages only post-reset samples.

## Timing
- Reset values: PCM=0x0000, PCM_VALID=0, DAC_OUT=0.
- Latency: for the CE of the last sample in a window at cycle t: s1_v high at t+1, avg_v high at t+2, PCM valid and PCM_VALID=1 at t+3. PCM holds until the next update.
- CE may be asserted on consecutive cycles; the pipeline accepts one sample per CLK with no stall.
- CE gaps of any length are legal; a window completes only after 2^AVG_LOG2 CE samples.
- Channel inputs are sampled only in CE cycles; changes between CEs are ignored.
- DAC_OUT changes at most once per CLK. With PCM constant, the ones count over any 65536 consecutive cycles equals PCM ±1.

## Test plan
1. Reset: hold RESET 3 cycles with CE toggling and channels = 0xFF -> PCM=0, PCM_VALID=0, DAC_OUT=0 throughout and on the first cycle after release.
2. Full scale, AVG_LOG2=3, VOLUME=0, MUTE=0, A=B=C=0xFF, CE every 4th CLK -> exactly one PCM_VALID pulse, 3 CLKs after the 8th CE, with PCM=0xBF40; next pulse 32 CLKs later.
3. Mute and attenuation: MUTE=3'b110, A=0x80, B=C=0xFF, VOLUME=0 -> PCM=0x2000; repeat with VOLUME=2 -> PCM=0x0800.
4. Averaging: 8 CE samples with A = 0,0,0,0,0xFF,0xFF,0xFF,0xFF and B=C muted -> PCM = (1020>>3)<<6 = 127·64 = 0x1FC0.
5. Sigma-delta: force PCM=0x8000 -> DAC_OUT alternates 0,1 starting from reset state; PCM=0x2000 -> exactly one 1 per 8 CLKs; PCM=0 -> DAC_OUT stays 0.
6. Reset mid-window plus back-to-back CE: 5 CEs at A=0xFF, RESET 1 cycle, then 8 consecutive CE cycles at A=0x10 (B,C muted) -> first PCM after reset = 0x0400, PCM_VALID 3 CLKs after the 8th CE.
